// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: select encodings, stage indices
// and the bit layout of a shadow-pipeline entry.
package hazard_pkg;

    localparam int SEL_RF   = 0;
    localparam int STG_EXE  = 0;
    localparam int STG_MEM  = 1;

    // Tag fields carried by every stage; stage 0 additionally keeps mem_r and its source operands.
    localparam int ENT_VLD  = 0;
    localparam int ENT_WB   = 1;
    localparam int ENT_DEST = 2;

    function automatic int tag_w(input int reg_w);
        return 2 + reg_w;
    endfunction

    function automatic int ofs_mr(input int reg_w);
        return 2 + reg_w;
    endfunction

    function automatic int ofs_use2(input int reg_w);
        return 3 + reg_w;
    endfunction

    function automatic int ofs_src1(input int reg_w);
        return 4 + reg_w;
    endfunction

    function automatic int ofs_src2(input int reg_w);
        return 4 + 2 * reg_w;
    endfunction

    function automatic int ent_w(input int reg_w);
        return 4 + 3 * reg_w;
    endfunction

endpackage

// File: rtl/hzd_shadow_stage.sv
// One shadow-pipeline entry: holds while the pipeline is stalled, otherwise loads the
// upstream entry or a bubble.
module hzd_shadow_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding for the IF/ID/EXE/MEM/WB pipeline, driven from
// a private shadow pipeline of in-flight destination tags.
module pipe_hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int NUM_STG = 3,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             freeze,
    output logic             stall_all,
    output logic [SEL_W-1:0] sel_src1,
    output logic [SEL_W-1:0] sel_src2,
    output logic [CNT_W-1:0] hazard_cnt
);

    localparam int TW   = tag_w(REG_W);
    localparam int EW   = ent_w(REG_W);
    localparam int O_MR = ofs_mr(REG_W);
    localparam int O_U2 = ofs_use2(REG_W);
    localparam int O_S1 = ofs_src1(REG_W);
    localparam int O_S2 = ofs_src2(REG_W);

    logic [EW-1:0] ent0_d;
    logic [EW-1:0] ent0_q;
    logic [TW-1:0] tag_q [1:NUM_STG-1];
    logic          raw_haz;
    logic          bubble;

    function automatic logic tag_hit(input logic [TW-1:0] t, input logic [REG_W-1:0] r);
        return t[ENT_VLD] & t[ENT_WB] & (t[ENT_DEST +: REG_W] == r);
    endfunction

    // Gated by rst so a stall cannot leak out while the block is held in reset.
    assign stall_all = rst & mem_busy;
    assign freeze    = stall_all | (id_valid & raw_haz & ~flush);
    assign bubble    = freeze | flush | ~id_valid;
    assign ent0_d    = {id_src2, id_src1, id_two_src, id_mem_r, id_dest, id_wb_en, 1'b1};

    hzd_shadow_stage #(.W(EW)) u_stg_exe (
        .clk    (clk),
        .rst_n  (rst),
        .hold   (stall_all),
        .bubble (bubble),
        .d      (ent0_d),
        .q      (ent0_q)
    );

    for (genvar g = STG_MEM; g < NUM_STG; g++) begin : g_stg
        if (g == STG_MEM) begin : g_first
            hzd_shadow_stage #(.W(TW)) u_stg (
                .clk    (clk),
                .rst_n  (rst),
                .hold   (stall_all),
                .bubble (1'b0),
                .d      (ent0_q[TW-1:0]),
                .q      (tag_q[g])
            );
        end else begin : g_rest
            hzd_shadow_stage #(.W(TW)) u_stg (
                .clk    (clk),
                .rst_n  (rst),
                .hold   (stall_all),
                .bubble (1'b0),
                .d      (tag_q[g-1]),
                .q      (tag_q[g])
            );
        end
    end

    always_comb begin
        logic hit;
        raw_haz  = 1'b0;
        sel_src1 = SEL_W'(SEL_RF);
        sel_src2 = SEL_W'(SEL_RF);

        hit = tag_hit(ent0_q[TW-1:0], id_src1)
            | (id_two_src & tag_hit(ent0_q[TW-1:0], id_src2));
        if (hit && (!fwd_en || ent0_q[O_MR])) begin
            raw_haz = 1'b1;
        end
        // Without forwarding every producer short of WB blocks; WB writes in the first half-cycle.
        for (int k = STG_MEM; k < NUM_STG - 1; k++) begin
            hit = tag_hit(tag_q[k], id_src1) | (id_two_src & tag_hit(tag_q[k], id_src2));
            if (hit && !fwd_en) begin
                raw_haz = 1'b1;
            end
        end

        // Walk from the oldest stage down so the nearest producer wins.
        if (fwd_en && ent0_q[ENT_VLD]) begin
            for (int k = NUM_STG - 1; k >= STG_MEM; k--) begin
                if (tag_hit(tag_q[k], ent0_q[O_S1 +: REG_W])) begin
                    sel_src1 = SEL_W'(k);
                end
                if (ent0_q[O_U2] && tag_hit(tag_q[k], ent0_q[O_S2 +: REG_W])) begin
                    sel_src2 = SEL_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazard_cnt <= '0;
        end else if (!stall_all && freeze && (hazard_cnt != '1)) begin
            hazard_cnt <= hazard_cnt + 1'b1;
        end
    end

endmodule
